udp_gmii_rx: RTL and testbench



---
 rtl/udp_gmii_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_udp_gmii_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_gmii_rx.sv
// GMII receive parser: preamble, Ethernet II / IPv4 / UDP header filtering, payload streaming,
// and CRC-32 frame check. Everything runs in the PHY receive clock domain.
module udp_gmii_rx #(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_0a_35_01_fe_c0,
    parameter logic [31:0] LOCAL_IP   = 32'hc0_a8_00_02,
    parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  GMII_RXD,
    input  logic        GMII_RXDV,
    output logic [7:0]  rx_data,
    output logic        rx_data_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic [15:0] rx_data_length,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic        one_pkt_done,
    output logic        pkt_ok
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, DROP
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    // MSB-first register fed with each byte LSB-first; its residue is the bit-reversed 0xDEBB20E3.
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  rxd_q;
    logic        rxdv_q;
    logic        in_valid_q, armed_q, armed_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        mac_local_q, mac_local_d, mac_bcast_q, mac_bcast_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_data_valid_q, rx_data_valid_d;
    logic        rx_sop_q, rx_sop_d, rx_eop_q, rx_eop_d;
    logic [15:0] rx_data_length_q, rx_data_length_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic        done_q, done_d, ok_q, ok_d;

    logic [47:0] mac_shift;
    logic [31:0] ip_shift;
    logic [7:0]  mac_exp, ip_exp, port_exp;
    logic [15:0] udp_len;
    logic        mac_local_hit, mac_bcast_hit;

    assign mac_shift     = LOCAL_MAC << {cnt_q[2:0], 3'b000};
    assign ip_shift      = LOCAL_IP << {cnt_q[1:0], 3'b000};
    assign mac_exp       = mac_shift[47:40];
    assign ip_exp        = ip_shift[31:24];
    assign port_exp      = cnt_q[0] ? LOCAL_PORT[7:0] : LOCAL_PORT[15:8];
    assign udp_len       = {len_hi_q, rxd_q};
    assign mac_local_hit = ((cnt_q == 16'd0) || mac_local_q) && (rxd_q == mac_exp);
    assign mac_bcast_hit = ((cnt_q == 16'd0) || mac_bcast_q) && (rxd_q == 8'hFF);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d          = state_q;
        cnt_d            = cnt_q;
        crc_d            = crc_q;
        mac_local_d      = mac_local_q;
        mac_bcast_d      = mac_bcast_q;
        len_hi_d         = len_hi_q;
        rx_data_d        = 8'h00;
        rx_data_valid_d  = 1'b0;
        rx_sop_d         = 1'b0;
        rx_eop_d         = 1'b0;
        rx_data_length_d = rx_data_length_q;
        src_mac_d        = src_mac_q;
        src_ip_d         = src_ip_q;
        src_port_d       = src_port_q;
        done_d           = 1'b0;
        ok_d             = 1'b0;
        // A frame already in flight when reset was released is ignored until the line goes idle.
        armed_d          = armed_q | (in_valid_q & ~rxdv_q);

        if (rxdv_q && state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER})
            crc_d = crc_step(crc_q, rxd_q);
        if (rxdv_q && state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD})
            cnt_d = cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (rxdv_q && armed_q)
                    state_d = (rxd_q == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == 8'hD5) begin
                    state_d = ETH_HDR;
                    cnt_d   = 16'd0;
                    crc_d   = 32'hFFFFFFFF;
                end else if (rxd_q != 8'h55) begin
                    state_d = DROP;
                end
            end
            ETH_HDR: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                end else if (cnt_q < 16'd6) begin
                    mac_local_d = mac_local_hit;
                    mac_bcast_d = mac_bcast_hit;
                    if (!mac_local_hit && !mac_bcast_hit) state_d = DROP;
                end else if (cnt_q < 16'd12) begin
                    src_mac_d = {src_mac_q[39:0], rxd_q};
                end else if (cnt_q == 16'd12) begin
                    if (rxd_q != 8'h08) state_d = DROP;
                end else if (rxd_q != 8'h00) begin
                    state_d = DROP;
                end else begin
                    state_d = IP_HDR;
                    cnt_d   = 16'd0;
                end
            end
            IP_HDR: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                end else if (cnt_q == 16'd0) begin
                    if (rxd_q != 8'h45) state_d = DROP;
                end else if (cnt_q == 16'd9) begin
                    if (rxd_q != 8'h11) state_d = DROP;
                end else if (cnt_q >= 16'd12 && cnt_q < 16'd16) begin
                    src_ip_d = {src_ip_q[23:0], rxd_q};
                end else if (cnt_q >= 16'd16) begin
                    if (rxd_q != ip_exp) begin
                        state_d = DROP;
                    end else if (cnt_q == 16'd19) begin
                        state_d = UDP_HDR;
                        cnt_d   = 16'd0;
                    end
                end
            end
            UDP_HDR: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                end else if (cnt_q < 16'd2) begin
                    src_port_d = {src_port_q[7:0], rxd_q};
                end else if (cnt_q < 16'd4) begin
                    if (rxd_q != port_exp) state_d = DROP;
                end else if (cnt_q == 16'd4) begin
                    len_hi_d = rxd_q;
                end else if (cnt_q == 16'd5) begin
                    if (udp_len < 16'd8) state_d = DROP;
                    else                 rx_data_length_d = udp_len - 16'd8;
                end else if (cnt_q == 16'd7) begin
                    state_d = (rx_data_length_q == 16'd0) ? TRAILER : PAYLOAD;
                    cnt_d   = 16'd0;
                end
            end
            PAYLOAD: begin
                if (!rxdv_q) begin
                    // Truncated payload: frame is reported, never as good.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    rx_data_d       = rxd_q;
                    rx_data_valid_d = 1'b1;
                    rx_sop_d        = (cnt_q == 16'd0);
                    rx_eop_d        = (cnt_q == rx_data_length_q - 16'd1);
                    if (rx_eop_d) state_d = TRAILER;
                end
            end
            TRAILER: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ok_d    = (crc_q == CRC_RESIDUE);
                end
            end
            DROP: begin
                if (!rxdv_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q          <= IDLE;
            rxd_q            <= 8'h00;
            rxdv_q           <= 1'b0;
            in_valid_q       <= 1'b0;
            armed_q          <= 1'b0;
            cnt_q            <= 16'd0;
            crc_q            <= 32'hFFFFFFFF;
            mac_local_q      <= 1'b0;
            mac_bcast_q      <= 1'b0;
            len_hi_q         <= 8'h00;
            rx_data_q        <= 8'h00;
            rx_data_valid_q  <= 1'b0;
            rx_sop_q         <= 1'b0;
            rx_eop_q         <= 1'b0;
            rx_data_length_q <= 16'd0;
            src_mac_q        <= 48'd0;
            src_ip_q         <= 32'd0;
            src_port_q       <= 16'd0;
            done_q           <= 1'b0;
            ok_q             <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q          <= state_d;
            rxd_q            <= GMII_RXD;
            rxdv_q           <= GMII_RXDV;
            in_valid_q       <= 1'b1;
            armed_q          <= armed_d;
            cnt_q            <= cnt_d;
            crc_q            <= crc_d;
            mac_local_q      <= mac_local_d;
            mac_bcast_q      <= mac_bcast_d;
            len_hi_q         <= len_hi_d;
            rx_data_q        <= rx_data_d;
            rx_data_valid_q  <= rx_data_valid_d;
            rx_sop_q         <= rx_sop_d;
            rx_eop_q         <= rx_eop_d;
            rx_data_length_q <= rx_data_length_d;
            src_mac_q        <= src_mac_d;
            src_ip_q         <= src_ip_d;
            src_port_q       <= src_port_d;
            done_q           <= done_d;
            ok_q             <= ok_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_data_valid  = rx_data_valid_q;
    assign rx_sop         = rx_sop_q;
    assign rx_eop         = rx_eop_q;
    assign rx_data_length = rx_data_length_q;
    assign src_mac        = src_mac_q;
    assign src_ip         = src_ip_q;
    assign src_port       = src_port_q;
    assign one_pkt_done   = done_q;
    assign pkt_ok         = ok_q;

endmodule

// File: tb/tb_udp_gmii_rx.sv
// Scoreboard bench for udp_gmii_rx: frames are built with a reference CRC-32, expected payload
// bytes and end-of-frame results are queued at send time and popped as the DUT emits them.
module tb_udp_gmii_rx;

    localparam logic [47:0] MY_MAC  = 48'h00_0a_35_01_fe_c0;
    localparam logic [31:0] MY_IP   = 32'hc0_a8_00_02;
    localparam logic [15:0] MY_PORT = 16'd8080;
    localparam int          PAY_OFS = 50;  // preamble+SFD (8) + headers (42)

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [7:0]  GMII_RXD = 8'h00;
    logic        GMII_RXDV = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_data_valid, rx_sop, rx_eop;
    logic [15:0] rx_data_length;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic        one_pkt_done, pkt_ok;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_bytes = 0;
    int   mon_dones = 0;
    bit   mon_en = 1'b1;
    exp_t exp_q[$];
    bit   done_q[$];
    exp_t mon_e;
    bit   mon_ok;
    logic [7:0] pay_q[$];
    logic [7:0] tx_q[$];

    udp_gmii_rx dut (
        .Clk(Clk), .Rst_n(Rst_n), .GMII_RXD(GMII_RXD), .GMII_RXDV(GMII_RXDV),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_data_length(rx_data_length), .src_mac(src_mac), .src_ip(src_ip), .src_port(src_port),
        .one_pkt_done(one_pkt_done), .pkt_ok(pkt_ok)
    );

    always #4 Clk = ~Clk;

    // Output monitor: every emitted byte and end-of-frame pulse must match the queued expectation.
    always @(negedge Clk) begin
        if (Rst_n && mon_en) begin
            if (rx_data_valid) begin
                mon_bytes++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL payload_byte: got unexpected byte %h sop=%b eop=%b, required none",
                             rx_data, rx_sop, rx_eop);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({rx_data, rx_sop, rx_eop} !== {mon_e.d, mon_e.sop, mon_e.eop}) begin
                        n_fail++;
                        $display("FAIL payload_byte: got %h sop=%b eop=%b, required %h sop=%b eop=%b",
                                 rx_data, rx_sop, rx_eop, mon_e.d, mon_e.sop, mon_e.eop);
                    end
                end
            end
            if (one_pkt_done) begin
                mon_dones++;
                n_checks++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pkt_done: got unexpected one_pkt_done pkt_ok=%b, required none", pkt_ok);
                end else begin
                    mon_ok = done_q.pop_front();
                    if (pkt_ok !== mon_ok) begin
                        n_fail++;
                        $display("FAIL pkt_ok: got %b, required %b", pkt_ok, mon_ok);
                    end
                end
            end
        end
    end

    task automatic build_frame(input logic [47:0] dmac, input logic [47:0] smac,
                               input logic [15:0] etype, input logic [31:0] dip,
                               input logic [31:0] sip, input logic [15:0] sport,
                               input logic [15:0] dport, input bit bad_fcs);
        logic [7:0]  fr[$];
        logic [31:0] crc;
        logic [15:0] ulen;
        logic [15:0] iplen;
        ulen  = 16'(pay_q.size() + 8);
        iplen = ulen + 16'd20;
        fr = {};
        for (int i = 5; i >= 0; i--) fr.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(smac[8*i +: 8]);
        fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
        fr.push_back(8'h45); fr.push_back(8'h00); fr.push_back(iplen[15:8]); fr.push_back(iplen[7:0]);
        fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h40); fr.push_back(8'h00);
        fr.push_back(8'h40); fr.push_back(8'h11); fr.push_back(8'h00); fr.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fr.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr.push_back(dip[8*i +: 8]);
        fr.push_back(sport[15:8]); fr.push_back(sport[7:0]);
        fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
        fr.push_back(ulen[15:8]);  fr.push_back(ulen[7:0]);
        fr.push_back(8'h00);       fr.push_back(8'h00);
        foreach (pay_q[i]) fr.push_back(pay_q[i]);
        while (fr.size() < 60) fr.push_back(8'h00);
        // Reference Ethernet FCS: reflected CRC-32, complemented, sent least significant byte first.
        crc = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            crc = crc ^ {24'd0, fr[i]};
            for (int k = 0; k < 8; k++)
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        if (bad_fcs) crc = crc ^ 32'h0000_0008;
        tx_q = {};
        for (int i = 0; i < 7; i++) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        foreach (fr[i]) tx_q.push_back(fr[i]);
        for (int i = 0; i < 4; i++) tx_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic expect_payload(input int delivered);
        exp_t e;
        for (int i = 0; i < delivered; i++) begin
            e.d   = pay_q[i];
            e.sop = (i == 0);
            e.eop = (i == pay_q.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge Clk); #1;
            GMII_RXD  = tx_q[i];
            GMII_RXDV = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            GMII_RXD  = 8'h00;
            GMII_RXDV = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 64 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(posedge Clk);
        @(posedge Clk);
        n_checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d bytes and %0d done pulses outstanding, required 0 and 0",
                     name, exp_q.size(), done_q.size());
            exp_q = {};
            done_q = {};
        end
    endtask

    task automatic check_fields(input string name, input logic [15:0] len, input logic [47:0] smac,
                                input logic [31:0] sip, input logic [15:0] sport);
        n_checks++;
        if ({rx_data_length, src_mac, src_ip, src_port} !== {len, smac, sip, sport}) begin
            n_fail++;
            $display("FAIL %s_fields: got len=%0d mac=%h ip=%h port=%0d, required len=%0d mac=%h ip=%h port=%0d",
                     name, rx_data_length, src_mac, src_ip, src_port, len, smac, sip, sport);
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({rx_data, rx_data_valid, rx_sop, rx_eop, rx_data_length, src_mac, src_ip, src_port,
             one_pkt_done, pkt_ok} !== '0) begin
            n_fail++;
            $display("FAIL %s: got data=%h v=%b sop=%b eop=%b len=%h mac=%h ip=%h port=%h done=%b ok=%b, required all zero",
                     name, rx_data, rx_data_valid, rx_sop, rx_eop, rx_data_length, src_mac, src_ip,
                     src_port, one_pkt_done, pkt_ok);
        end
    endtask

    task automatic send_good(input string name, input logic [47:0] dmac, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [15:0] sport, input bit bad_fcs);
        build_frame(dmac, smac, 16'h0800, MY_IP, sip, sport, MY_PORT, bad_fcs);
        expect_payload(pay_q.size());
        done_q.push_back(!bad_fcs);
        drive_range(0, tx_q.size());
        idle(4);
        wait_drain(name);
        check_fields(name, 16'(pay_q.size()), smac, sip, sport);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        idle(3);
        check_zero("reset_state");
        Rst_n = 1'b1;
        idle(3);
        check_zero("idle_after_reset");
    endtask

    task automatic test_unicast();
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_good("unicast", MY_MAC, 48'h11_22_33_44_55_66, 32'hc0_a8_00_0a, 16'd1234, 1'b0);
    endtask

    task automatic test_bad_fcs();
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_good("bad_fcs", MY_MAC, 48'h11_22_33_44_55_66, 32'hc0_a8_00_0a, 16'd1234, 1'b1);
    endtask

    task automatic test_broadcast();
        pay_q = '{8'h1C};
        send_good("broadcast", 48'hFF_FF_FF_FF_FF_FF, 48'h02_aa_bb_cc_dd_ee, 32'h0a_00_00_07,
                  16'd5000, 1'b0);
    endtask

    task automatic test_empty_payload();
        pay_q = {};
        send_good("empty", MY_MAC, 48'h02_00_00_00_00_01, 32'h0a_01_02_03, 16'd77, 1'b0);
    endtask

    task automatic test_filter();
        int b0, d0;
        b0 = mon_bytes;
        d0 = mon_dones;
        pay_q = '{8'h01, 8'h02, 8'h03};
        build_frame(MY_MAC, 48'h02_00_00_00_00_02, 16'h0800, MY_IP, 32'h0a_00_00_01, 16'd9, 16'd8081, 1'b0);
        drive_range(0, tx_q.size()); idle(1);
        build_frame(MY_MAC, 48'h02_00_00_00_00_02, 16'h0800, 32'hc0_a8_00_03, 32'h0a_00_00_01, 16'd9, MY_PORT, 1'b0);
        drive_range(0, tx_q.size()); idle(1);
        build_frame(MY_MAC, 48'h02_00_00_00_00_02, 16'h0806, MY_IP, 32'h0a_00_00_01, 16'd9, MY_PORT, 1'b0);
        drive_range(0, tx_q.size()); idle(1);
        build_frame(48'h00_0a_35_01_fe_c1, 48'h02_00_00_00_00_02, 16'h0800, MY_IP, 32'h0a_00_00_01, 16'd9, MY_PORT, 1'b0);
        drive_range(0, tx_q.size());
        idle(6);
        n_checks++;
        if (mon_bytes != b0 || mon_dones != d0) begin
            n_fail++;
            $display("FAIL filter: got %0d bytes %0d done pulses, required 0 and 0",
                     mon_bytes - b0, mon_dones - d0);
        end
    endtask

    task automatic test_truncated_back_to_back();
        pay_q = {};
        for (int i = 0; i < 100; i++) pay_q.push_back(8'(i * 7 + 3));
        build_frame(MY_MAC, 48'h02_00_00_00_00_03, 16'h0800, MY_IP, 32'h0a_00_00_03, 16'd300, MY_PORT, 1'b0);
        expect_payload(10);
        done_q.push_back(1'b0);
        drive_range(0, PAY_OFS + 10);
        idle(1);
        pay_q = '{8'h5A, 8'hA5, 8'h00, 8'hFF, 8'h55, 8'hD5};
        send_good("after_gap", MY_MAC, 48'h02_00_00_00_00_04, 32'h0a_00_00_04, 16'd301, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL truncated: got %0d leftover bytes, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_payload();
        pay_q = {};
        for (int i = 0; i < 100; i++) pay_q.push_back(8'(i));
        build_frame(MY_MAC, 48'h02_00_00_00_00_05, 16'h0800, MY_IP, 32'h0a_00_00_05, 16'd400, MY_PORT, 1'b0);
        mon_en = 1'b0;
        drive_range(0, PAY_OFS + 20);
        #2 Rst_n = 1'b0;
        #1 check_zero("reset_mid_payload");
        mon_en = 1'b1;
        drive_range(PAY_OFS + 20, PAY_OFS + 23);
        Rst_n = 1'b1;
        drive_range(PAY_OFS + 23, tx_q.size());
        idle(4);
        check_zero("ignored_after_reset");
        pay_q = '{8'h10, 8'h20, 8'h30};
        send_good("after_reset", MY_MAC, 48'h02_00_00_00_00_06, 32'h0a_00_00_06, 16'd401, 1'b0);
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_bad_fcs();
        test_broadcast();
        test_empty_payload();
        test_filter();
        test_truncated_back_to_back();
        test_reset_mid_payload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
